// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: stage indices, FSM encoding
// and the per-rule hold/flush bank masks.
package pipe_ctrl_pkg;

    localparam int NSTG      = 4;
    localparam int STG_IFID  = 0;
    localparam int STG_IDEX  = 1;
    localparam int STG_EXMEM = 2;
    localparam int STG_MEMWB = 3;

    typedef logic [NSTG-1:0] bank_t;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_MCYC = 2'd2
    } state_e;

    // "Through stage N" masks cover every bank from IF/ID up to and including N.
    localparam bank_t MSK_ALL     = '1;
    localparam bank_t TRAP_FLUSH  = (bank_t'(1) << (STG_EXMEM + 1)) - bank_t'(1);
    localparam bank_t STALL_HOLD  = (bank_t'(1) << (STG_EXMEM + 1)) - bank_t'(1);
    localparam bank_t STALL_FLUSH = bank_t'(1) << STG_MEMWB;
    localparam bank_t MCYC_HOLD   = (bank_t'(1) << (STG_IDEX + 1)) - bank_t'(1);
    localparam bank_t MCYC_FLUSH  = bank_t'(1) << STG_EXMEM;
    localparam bank_t JUMP_FLUSH  = (bank_t'(1) << (STG_IDEX + 1)) - bank_t'(1);
    localparam bank_t LDU_HOLD    = bank_t'(1) << STG_IFID;
    localparam bank_t LDU_FLUSH   = bank_t'(1) << STG_IDEX;

endpackage

// File: rtl/pipe_ctrl_mcyc_cnt.sv
// Multi-cycle op watchdog: saturating cycle counter plus a sticky timeout flag
// that sets when the count reaches MCYC_TO.
module pipe_ctrl_mcyc_cnt #(
    parameter int MCYC_TO = 64
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr_i,
    input  logic en_i,
    input  logic tout_clr_i,
    output logic tout_o
);

    localparam int CW = $clog2(MCYC_TO + 1);
    localparam logic [CW-1:0] TO_MAX = CW'(MCYC_TO);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tout_q, tout_d;

    always_comb begin
        cnt_d  = cnt_q;
        tout_d = tout_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && cnt_q != TO_MAX)
            cnt_d = cnt_q + 1'b1;
        if (tout_clr_i)
            tout_d = 1'b0;
        else if (cnt_d == TO_MAX)
            tout_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= '0;
            tout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tout_q <= tout_d;
        end
    end

    assign tout_o = tout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage core: combinational hold/flush/PC control
// from hazard, stall, multi-cycle, jump and trap requests.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int AW      = 32,
    parameter int MCYC_TO = 64
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          ld_use_hzd_i,
    input  logic          mcyc_start_i,
    input  logic          mcyc_done_i,
    input  logic          mem_stall_i,
    input  logic          jump_req_i,
    input  logic [AW-1:0] jump_addr_i,
    input  logic          trap_req_i,
    input  logic [AW-1:0] trap_addr_i,
    output logic [3:0]    hold_o,
    output logic [3:0]    flush_o,
    output logic          pc_hold_o,
    output logic          pc_redir_o,
    output logic [AW-1:0] pc_redir_addr_o,
    output logic          mcyc_busy_o,
    output logic          mcyc_tout_o
);

    state_e        state_q, state_d;
    logic          jpend_q, jpend_d;
    logic [AW-1:0] jaddr_q, jaddr_d;
    logic          cnt_clr, tout_clr;

    always_comb begin
        hold_o          = '0;
        flush_o         = '0;
        pc_hold_o       = 1'b0;
        pc_redir_o      = 1'b0;
        pc_redir_addr_o = '0;
        state_d         = state_q;
        jpend_d         = jpend_q;
        jaddr_d         = jaddr_q;
        cnt_clr         = 1'b0;
        tout_clr        = 1'b0;

        if (state_q == ST_BOOT) begin
            flush_o   = MSK_ALL;
            pc_hold_o = 1'b1;
            state_d   = ST_RUN;
        end else if (trap_req_i) begin
            flush_o         = TRAP_FLUSH;
            pc_redir_o      = 1'b1;
            pc_redir_addr_o = trap_addr_i;
            state_d         = ST_RUN;
            jpend_d         = 1'b0;
            cnt_clr         = 1'b1;
            tout_clr        = 1'b1;
        end else begin
            // Entry waits out a memory stall; start+done in MCYC re-arms for the next op.
            if (mcyc_start_i && !mem_stall_i &&
                (state_q == ST_RUN || mcyc_done_i)) begin
                state_d = ST_MCYC;
                cnt_clr = 1'b1;
            end else if (state_q == ST_MCYC && mcyc_done_i) begin
                state_d = ST_RUN;
            end

            if (mem_stall_i) begin
                pc_hold_o = 1'b1;
                hold_o    = STALL_HOLD;
                flush_o   = STALL_FLUSH;
                if (jump_req_i) begin
                    jpend_d = 1'b1;
                    jaddr_d = jump_addr_i;
                end
            end else if (state_q == ST_MCYC && !mcyc_done_i) begin
                pc_hold_o = 1'b1;
                hold_o    = MCYC_HOLD;
                flush_o   = MCYC_FLUSH;
            end else if (jpend_q || jump_req_i) begin
                flush_o         = JUMP_FLUSH;
                pc_redir_o      = 1'b1;
                pc_redir_addr_o = jpend_q ? jaddr_q : jump_addr_i;
                jpend_d         = 1'b0;
            end else if (ld_use_hzd_i) begin
                pc_hold_o = 1'b1;
                hold_o    = LDU_HOLD;
                flush_o   = LDU_FLUSH;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_BOOT;
            jpend_q <= 1'b0;
            jaddr_q <= '0;
        end else begin
            state_q <= state_d;
            jpend_q <= jpend_d;
            jaddr_q <= jaddr_d;
        end
    end

    pipe_ctrl_mcyc_cnt #(
        .MCYC_TO(MCYC_TO)
    ) u_mcyc_cnt (
        .clk        (clk),
        .rstn       (rstn),
        .clr_i      (cnt_clr),
        .en_i       (state_q == ST_MCYC),
        .tout_clr_i (tout_clr),
        .tout_o     (mcyc_tout_o)
    );

    assign mcyc_busy_o = (state_q == ST_MCYC);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: table of per-cycle vectors with a scoreboard queue of
// expected outputs, plus a hand-written async-reset sequence during MCYC.
module tb_pipe_ctrl;

    localparam int AW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          ld_use_hzd, mcyc_start, mcyc_done, mem_stall, jump_req, trap_req;
    logic [AW-1:0] jump_addr, trap_addr;
    logic [3:0]    hold, flush;
    logic          pc_hold, pc_redir, mcyc_busy, mcyc_tout;
    logic [AW-1:0] pc_redir_addr;

    always #5 clk = ~clk;

    pipe_ctrl #(.AW(AW), .MCYC_TO(TO)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .ld_use_hzd_i    (ld_use_hzd),
        .mcyc_start_i    (mcyc_start),
        .mcyc_done_i     (mcyc_done),
        .mem_stall_i     (mem_stall),
        .jump_req_i      (jump_req),
        .jump_addr_i     (jump_addr),
        .trap_req_i      (trap_req),
        .trap_addr_i     (trap_addr),
        .hold_o          (hold),
        .flush_o         (flush),
        .pc_hold_o       (pc_hold),
        .pc_redir_o      (pc_redir),
        .pc_redir_addr_o (pc_redir_addr),
        .mcyc_busy_o     (mcyc_busy),
        .mcyc_tout_o     (mcyc_tout)
    );

    typedef struct packed {
        logic ld, st, dn, ms, jr;
        logic [AW-1:0] ja;
        logic tr;
        logic [AW-1:0] ta;
    } in_t;

    typedef struct packed {
        logic [3:0] hold, flush;
        logic pch, redir;
        logic [AW-1:0] addr;
        logic busy, tout;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    vec_t tbl[$];
    out_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic in_t ii(logic ld, st, dn, ms, jr, logic [AW-1:0] ja, logic tr, logic [AW-1:0] ta);
        return '{ld: ld, st: st, dn: dn, ms: ms, jr: jr, ja: ja, tr: tr, ta: ta};
    endfunction

    function automatic out_t eo(logic [3:0] h, f, logic pch, rd, logic [AW-1:0] a, logic b, t);
        return '{hold: h, flush: f, pch: pch, redir: rd, addr: a, busy: b, tout: t};
    endfunction

    function automatic out_t o_z(logic b, t);       return eo(4'b0000, 4'b0000, 1'b0, 1'b0, '0, b, t); endfunction
    function automatic out_t o_mc(logic t);         return eo(4'b0011, 4'b0100, 1'b1, 1'b0, '0, 1'b1, t); endfunction
    function automatic out_t o_st(logic b);         return eo(4'b0111, 4'b1000, 1'b1, 1'b0, '0, b, 1'b0); endfunction
    function automatic out_t o_jmp(logic [AW-1:0] a); return eo(4'b0000, 4'b0011, 1'b0, 1'b1, a, 1'b0, 1'b0); endfunction
    function automatic out_t o_trap(logic [AW-1:0] a, logic b, t); return eo(4'b0000, 4'b0111, 1'b0, 1'b1, a, b, t); endfunction
    function automatic out_t o_boot();              return eo(4'b0000, 4'b1111, 1'b1, 1'b0, '0, 1'b0, 1'b0); endfunction

    function automatic in_t idle();                 return ii(0, 0, 0, 0, 0, '0, 0, '0); endfunction

    function automatic out_t cur();
        return '{hold: hold, flush: flush, pch: pc_hold, redir: pc_redir,
                 addr: pc_redir_addr, busy: mcyc_busy, tout: mcyc_tout};
    endfunction

    task automatic drive(input in_t i);
        ld_use_hzd = i.ld;
        mem_stall  = i.st;
        mcyc_done  = i.dn;
        mcyc_start = i.ms;
        jump_req   = i.jr;
        jump_addr  = i.ja;
        trap_req   = i.tr;
        trap_addr  = i.ta;
    endtask

    task automatic cmp(input string nm, input out_t a, input out_t e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got hold=%b flush=%b pch=%b redir=%b addr=%h busy=%b tout=%b; want hold=%b flush=%b pch=%b redir=%b addr=%h busy=%b tout=%b",
                     nm, a.hold, a.flush, a.pch, a.redir, a.addr, a.busy, a.tout,
                     e.hold, e.flush, e.pch, e.redir, e.addr, e.busy, e.tout);
        end
    endtask

    // One clock per vector: drive just after the edge, score at the falling edge.
    task automatic step(input vec_t v, input string nm);
        @(posedge clk);
        #1 drive(v.i);
        exp_q.push_back(v.o);
        @(negedge clk);
        cmp(nm, cur(), exp_q.pop_front());
    endtask

    task automatic add(input in_t i, input out_t o);
        tbl.push_back('{i: i, o: o});
    endtask

    initial begin
        //   ld st dn ms jr ja        tr ta
        add(idle(),                                  o_z(0, 0));           // RUN free flow
        add(ii(1, 0, 0, 0, 0, '0, 0, '0),            eo(4'b0001, 4'b0010, 1, 0, '0, 0, 0));
        add(idle(),                                  o_z(0, 0));
        add(ii(0, 0, 0, 1, 0, '0, 0, '0),            o_z(0, 0));           // enter MCYC
        add(idle(),                                  o_mc(0));
        add(idle(),                                  o_mc(0));
        add(ii(0, 0, 1, 0, 0, '0, 0, '0),            o_z(1, 0));           // done cycle flows
        add(idle(),                                  o_z(0, 0));
        add(ii(0, 1, 0, 0, 0, '0, 0, '0),            o_st(0));             // stall w/ jump in cycle 2
        add(ii(0, 1, 0, 0, 1, 32'h80, 0, '0),        o_st(0));
        add(ii(0, 1, 0, 0, 0, '0, 0, '0),            o_st(0));
        add(idle(),                                  o_jmp(32'h80));
        add(idle(),                                  o_z(0, 0));
        add(ii(1, 0, 0, 0, 1, 32'h44, 0, '0),        o_jmp(32'h44));       // jump beats load-use
        add(ii(0, 1, 0, 0, 1, 32'h200, 0, '0),       o_st(0));             // newer pending jump wins
        add(ii(0, 1, 0, 0, 1, 32'h300, 0, '0),       o_st(0));
        add(idle(),                                  o_jmp(32'h300));
        add(ii(0, 0, 0, 1, 0, '0, 0, '0),            o_z(0, 0));           // trap during MCYC+stall
        add(idle(),                                  o_mc(0));
        add(ii(0, 1, 0, 0, 0, '0, 1, 32'h100),       o_trap(32'h100, 1, 0));
        add(idle(),                                  o_z(0, 0));
        add(ii(0, 0, 0, 1, 0, '0, 0, '0),            o_z(0, 0));           // timeout at MCYC_TO=4
        add(idle(),                                  o_mc(0));
        add(idle(),                                  o_mc(0));
        add(idle(),                                  o_mc(0));
        add(idle(),                                  o_mc(0));
        add(idle(),                                  o_mc(1));
        add(idle(),                                  o_mc(1));
        add(ii(0, 0, 0, 0, 0, '0, 1, 32'h100),       o_trap(32'h100, 1, 1));
        add(idle(),                                  o_z(0, 0));
        add(ii(0, 1, 0, 1, 0, '0, 0, '0),            o_st(0));             // start deferred by stall
        add(ii(0, 0, 0, 1, 0, '0, 0, '0),            o_z(0, 0));
        add(ii(0, 0, 1, 1, 0, '0, 0, '0),            o_z(1, 0));           // back-to-back op
        add(idle(),                                  o_mc(0));
        add(ii(0, 0, 1, 0, 0, '0, 0, '0),            o_z(1, 0));
        add(idle(),                                  o_z(0, 0));
        add(ii(0, 0, 0, 1, 0, '0, 1, 32'h10),        o_trap(32'h10, 0, 0)); // trap blocks entry
        add(idle(),                                  o_z(0, 0));

        rstn = 1'b0;
        drive(idle());
        @(negedge clk);
        exp_q.push_back(o_boot());
        cmp("reset", cur(), exp_q.pop_front());
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        exp_q.push_back(o_boot());
        cmp("boot", cur(), exp_q.pop_front());

        foreach (tbl[k]) step(tbl[k], $sformatf("vec%0d", k));

        // Async reset while in MCYC with the timeout flag set.
        step('{i: ii(0, 0, 0, 1, 0, '0, 0, '0), o: o_z(0, 0)}, "ar_start");
        for (int k = 0; k < TO; k++) step('{i: idle(), o: o_mc(0)}, $sformatf("ar_mc%0d", k));
        step('{i: idle(), o: o_mc(1)}, "ar_tout");
        @(posedge clk);
        #3 rstn = 1'b0;
        #1 cmp("async_rst", cur(), o_boot());
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        cmp("reboot", cur(), o_boot());
        step('{i: idle(), o: o_z(0, 0)}, "reboot_run");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
